lx32_fetch: RTL and testbench

LX32_FETCH -- requirements
Module: lx32_fetch

---
 rtl/lx32_fetch_if.sv | 31 +++
 rtl/lx32_fetch.sv | 133 +++++++++++++
 tb/tb_lx32_fetch.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lx32_fetch_if.sv
// Fetch-unit bus bundle: redirect from execute, instruction-memory request/response,
// and the decode-side valid/ready handoff. The fetch unit is the master.
interface lx32_fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   modport master (
      input  redirect_valid, redirect_pc,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  if_ready,
      output imem_req, imem_addr,
      output if_valid, if_pc, if_instr
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output imem_gnt, imem_rvalid, imem_rdata,
      output if_ready,
      input  imem_req, imem_addr,
      input  if_valid, if_pc, if_instr
   );
endinterface

// File: rtl/lx32_fetch.sv
// Instruction fetch: issues word requests under a 2-credit limit, pairs in-order responses
// with their request PCs, buffers them in a 2-entry FIFO and drops responses stale after a redirect.
module lx32_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   lx32_fetch_if.master  bus
);

   logic [31:0] r_fetch_pc;
   logic [1:0]  r_outstanding;
   logic [1:0]  r_drop_cnt;
   logic [1:0]  r_fifo_cnt;
   logic [31:0] r_pcq  [2];
   logic [63:0] r_fifo [2];

   logic [31:0] w_fetch_addr;
   logic        w_pop;
   logic        w_rsp;
   logic        w_rsp_keep;
   logic        w_rsp_drop;
   logic [2:0]  w_credits;
   logic        w_req;
   logic        w_grant;
   logic [63:0] w_entry;
   logic [31:0] w_pcq_nxt  [2];
   logic [63:0] w_fifo_nxt [2];
   logic [1:0]  w_out_nxt;
   logic [1:0]  w_fifo_cnt_nxt;
   logic [1:0]  w_drop_nxt;
   logic [1:0]  w_drop_redir;

   assign w_fetch_addr = {r_fetch_pc[31:2], 2'b00};
   assign w_pop        = (r_fifo_cnt != 2'd0) && bus.if_ready;

   // Responses with nothing in flight are protocol violations and are ignored outright.
   assign w_rsp      = bus.imem_rvalid && ((r_outstanding != 2'd0) || (r_drop_cnt != 2'd0));
   assign w_rsp_drop = w_rsp && (r_drop_cnt != 2'd0);
   assign w_rsp_keep = w_rsp && (r_drop_cnt == 2'd0);

   // A slot freed by this cycle's pop is reusable immediately, which is what lets the
   // pipe stream one instruction per cycle with only two credits.
   assign w_credits = 3'(r_outstanding) + 3'(r_drop_cnt) + 3'(r_fifo_cnt) - 3'(w_pop);
   assign w_req     = !rst && !bus.redirect_valid && (w_credits < 3'd2);
   assign w_grant   = w_req && bus.imem_gnt;

   assign w_entry      = {r_pcq[0], bus.imem_rdata};
   assign w_drop_nxt   = r_drop_cnt - 2'(w_rsp_drop);
   assign w_drop_redir = r_outstanding + r_drop_cnt - 2'(w_rsp);

   always_comb begin
      w_pcq_nxt = r_pcq;
      w_out_nxt = r_outstanding;
      case ({w_grant, w_rsp_keep})
         2'b10: begin
            w_pcq_nxt[r_outstanding[0]] = w_fetch_addr;
            w_out_nxt = r_outstanding + 2'd1;
         end
         2'b01: begin
            w_pcq_nxt[0] = r_pcq[1];
            w_out_nxt = r_outstanding - 2'd1;
         end
         2'b11: begin
            if (r_outstanding == 2'd1) begin
               w_pcq_nxt[0] = w_fetch_addr;
            end else begin
               w_pcq_nxt[0] = r_pcq[1];
               w_pcq_nxt[1] = w_fetch_addr;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_fifo_nxt     = r_fifo;
      w_fifo_cnt_nxt = r_fifo_cnt;
      case ({w_rsp_keep, w_pop})
         2'b10: begin
            w_fifo_nxt[r_fifo_cnt[0]] = w_entry;
            w_fifo_cnt_nxt = r_fifo_cnt + 2'd1;
         end
         2'b01: begin
            w_fifo_nxt[0] = r_fifo[1];
            w_fifo_cnt_nxt = r_fifo_cnt - 2'd1;
         end
         2'b11: begin
            if (r_fifo_cnt == 2'd1) begin
               w_fifo_nxt[0] = w_entry;
            end else begin
               w_fifo_nxt[0] = r_fifo[1];
               w_fifo_nxt[1] = w_entry;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= 2'd0;
         r_drop_cnt    <= 2'd0;
         r_fifo_cnt    <= 2'd0;
      end else if (bus.redirect_valid) begin
         // Everything in flight becomes stale; same-cycle pops and pushes are discarded.
         r_fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
         r_outstanding <= 2'd0;
         r_drop_cnt    <= w_drop_redir;
         r_fifo_cnt    <= 2'd0;
      end else begin
         if (w_grant) begin
            r_fetch_pc <= w_fetch_addr + 32'd4;
         end
         r_outstanding <= w_out_nxt;
         r_drop_cnt    <= w_drop_nxt;
         r_fifo_cnt    <= w_fifo_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_pcq  <= w_pcq_nxt;
      r_fifo <= w_fifo_nxt;
   end

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = w_fetch_addr;
   assign bus.if_valid  = (r_fifo_cnt != 2'd0);
   assign bus.if_pc     = r_fifo[0][63:32];
   assign bus.if_instr  = r_fifo[0][31:0];

endmodule

// File: tb/tb_lx32_fetch.sv
// Scoreboard bench for lx32_fetch: a latency-configurable memory model feeds two instances
// (RESET_PC 0 and FFFF_FFFC); grants push expected {pc, instr}, decode pops compare.
module tb_lx32_fetch;

   logic clk;
   logic rst;

   lx32_fetch_if b0 ();
   lx32_fetch_if b1 ();

   lx32_fetch #(.RESET_PC(32'h0000_0000)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   lx32_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      int          due;
   } pend_t;

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   pend_t        pend0[$];
   pend_t        pend1[$];
   logic [63:0]  exp0[$];
   logic [31:0]  pops1[$];
   logic [31:0]  pop_log[$];
   int           pop_cnt = 0;
   int           grant_cnt = 0;

   int           gnt_mode = 0;
   int           rdy_mode = 1;
   int           lat_lo = 1;
   int           lat_hi = 1;
   bit           redir_req = 0;
   logic [31:0]  redir_pc = 32'h0;
   bit           rst_req = 1;
   bit           spur = 0;
   bit           prev_rst = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h0000_0010;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cycle();
      logic        v0;
      logic        v1;
      logic [63:0] e;
      pend_t       p;
      @(negedge clk);
      cyc++;
      rst = rst_req;
      b0.redirect_valid = redir_req;
      b0.redirect_pc    = redir_pc;
      b0.imem_gnt       = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
      b0.if_ready       = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 3) != 0);
      v0 = (pend0.size() > 0) && (pend0[0].due <= cyc);
      b0.imem_rvalid    = v0 || spur;
      b0.imem_rdata     = v0 ? mem_word(pend0[0].a) : 32'hDEAD_BEEF;
      v1 = (pend1.size() > 0) && (pend1[0].due <= cyc);
      b1.imem_rvalid    = v1;
      b1.imem_rdata     = v1 ? mem_word(pend1[0].a) : 32'hDEAD_BEEF;
      #1;
      if (v0) void'(pend0.pop_front());
      if (v1) void'(pend1.pop_front());
      if (rst_req) begin
         chk("rst_req_low", b0.imem_req, 0);
         if (prev_rst) chk("rst_valid_low", b0.if_valid, 0);
         exp0.delete();
         pops1.delete();
      end else begin
         if (redir_req) begin
            chk("redir_req_low", b0.imem_req, 0);
            exp0.delete();
         end else begin
            if (b0.if_valid && b0.if_ready) begin
               chk("sb_nonempty", exp0.size() != 0, 1);
               if (exp0.size() != 0) begin
                  e = exp0.pop_front();
                  chk("if_pc", b0.if_pc, e[63:32]);
                  chk("if_instr", b0.if_instr, e[31:0]);
               end
               pop_cnt++;
               pop_log.push_back(b0.if_pc);
            end
            if (b0.imem_req && b0.imem_gnt) begin
               p.a = b0.imem_addr;
               p.due = cyc + int'($urandom_range(lat_lo, lat_hi));
               pend0.push_back(p);
               exp0.push_back({b0.imem_addr, mem_word(b0.imem_addr)});
               grant_cnt++;
            end
         end
         if (b1.if_valid) pops1.push_back(b1.if_pc);
         if (b1.imem_req) begin
            p.a = b1.imem_addr;
            p.due = cyc + 1;
            pend1.push_back(p);
         end
      end
      prev_rst = rst_req;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          g;
      int          p;
      logic [31:0] pc_h;
      logic [31:0] in_h;

      rst = 1'b1;
      b0.redirect_valid = 0; b0.redirect_pc = 0; b0.imem_gnt = 0;
      b0.imem_rvalid = 0; b0.imem_rdata = 0; b0.if_ready = 0;
      b1.redirect_valid = 0; b1.redirect_pc = 0; b1.imem_gnt = 1;
      b1.imem_rvalid = 0; b1.imem_rdata = 0; b1.if_ready = 1;

      // Reset, first fetch, latency and no bypass
      rst_req = 1; gnt_mode = 0; rdy_mode = 1;
      repeat (3) cycle();
      rst_req = 0; gnt_mode = 1;
      cycle();
      chk("post_rst_req", b0.imem_req, 1);
      chk("post_rst_addr", b0.imem_addr, 32'h0);
      cycle();
      chk("no_bypass", b0.if_valid, 0);
      chk("next_addr", b0.imem_addr, 32'h4);
      cycle();
      chk("lat_valid", b0.if_valid, 1);
      chk("first_pc", b0.if_pc, 32'h0);
      chk("first_instr", b0.if_instr, 32'h0000_0013);

      // Steady streaming
      p = pop_cnt;
      repeat (20) cycle();
      chk("throughput", pop_cnt - p, 20);
      chk("d1_len", pops1.size() >= 2, 1);
      chk("d1_pc0", pops1[0], 32'hFFFF_FFFC);
      chk("d1_pc1", pops1[1], 32'h0000_0000);

      // Decode stall with memory always granting
      rst_req = 1;
      repeat (2) cycle();
      rst_req = 0; rdy_mode = 0; gnt_mode = 1;
      g = grant_cnt;
      repeat (3) cycle();
      chk("stall_valid", b0.if_valid, 1);
      pc_h = b0.if_pc; in_h = b0.if_instr;
      repeat (3) cycle();
      chk("stall_grants", grant_cnt - g, 2);
      chk("stall_req_low", b0.imem_req, 0);
      chk("stall_pc_hold", b0.if_pc, pc_h);
      chk("stall_instr_hold", b0.if_instr, in_h);
      pop_log.delete();
      rdy_mode = 1;
      repeat (6) cycle();
      chk("stall_log_len", pop_log.size() >= 2, 1);
      chk("stall_pop0", pop_log[0], 32'h0);
      chk("stall_pop1", pop_log[1], 32'h4);

      // Redirect with two requests outstanding
      rst_req = 1;
      repeat (2) cycle();
      rst_req = 0; lat_lo = 3; lat_hi = 3;
      g = grant_cnt;
      repeat (2) cycle();
      chk("two_outstanding", grant_cnt - g, 2);
      redir_req = 1; redir_pc = 32'h0000_0102;
      cycle();
      redir_req = 0;
      cycle();
      chk("redir_addr", b0.imem_addr, 32'h0000_0100);
      chk("redir_valid_low", b0.if_valid, 0);
      pop_log.delete();
      repeat (15) cycle();
      chk("redir_log_len", pop_log.size() >= 1, 1);
      chk("redir_first_pc", pop_log[0], 32'h0000_0100);

      // Redirect coinciding with a pop
      lat_lo = 1; lat_hi = 1;
      repeat (6) cycle();
      redir_req = 1; redir_pc = 32'h0000_2000;
      cycle();
      chk("redir_pop_cond", b0.if_valid && b0.if_ready, 1);
      redir_req = 0;
      cycle();
      chk("redir_pop_flush", b0.if_valid, 0);
      pop_log.delete();
      repeat (10) cycle();
      chk("rp_log_len", pop_log.size() >= 2, 1);
      chk("rp_pop0", pop_log[0], 32'h0000_2000);
      chk("rp_pop1", pop_log[1], 32'h0000_2004);

      // Reset while a request is outstanding; its response lands right after release
      gnt_mode = 0;
      repeat (8) cycle();
      chk("drain_empty", exp0.size(), 0);
      lat_lo = 2; lat_hi = 2; gnt_mode = 1;
      cycle();
      gnt_mode = 0; rst_req = 1;
      cycle();
      rst_req = 0;
      cycle();
      chk("mid_rst_req", b0.imem_req, 1);
      chk("mid_rst_addr", b0.imem_addr, 32'h0);
      cycle();
      chk("mid_rst_valid", b0.if_valid, 0);
      lat_lo = 1; lat_hi = 1; gnt_mode = 1;
      pop_log.delete();
      repeat (10) cycle();
      chk("mid_rst_len", pop_log.size() >= 1, 1);
      chk("mid_rst_pop0", pop_log[0], 32'h0);

      // Spurious response with nothing in flight
      gnt_mode = 0;
      repeat (6) cycle();
      spur = 1;
      cycle();
      spur = 0;
      cycle();
      chk("spur_valid", b0.if_valid, 0);
      gnt_mode = 1;
      p = pop_cnt;
      repeat (10) cycle();
      chk("post_spur_progress", (pop_cnt - p) >= 5, 1);

      // Random grants, latency, backpressure and redirects
      gnt_mode = 2; rdy_mode = 2; lat_lo = 1; lat_hi = 3;
      p = pop_cnt;
      repeat (400) begin
         redir_req = ($urandom_range(0, 19) == 0);
         redir_pc  = $urandom;
         cycle();
      end
      redir_req = 0;
      gnt_mode = 0; rdy_mode = 1;
      repeat (12) cycle();
      chk("rand_drain_empty", exp0.size(), 0);
      chk("rand_progress", (pop_cnt - p) > 50, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
